// File: rtl/detector_scheduler_pkg.sv
// Shared definitions for the detector scheduler: FSM state encoding.
package detector_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLR   = 3'd1;
  localparam state_t S_SHIFT = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// wrapping around. Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_next,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin : pick
    int p;
    gnt_next = '0;
    idx      = '0;
    any      = 1'b0;
    p        = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!any && req[p]) begin
        any         = 1'b1;
        gnt_next[p] = 1'b1;
        idx         = p[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/detector_scheduler.sv
// Shares one bit-serial sequence detector between N_REQ requesters.
// A granted word is shifted MSB-first into the detector after a one-cycle
// detector clear; det_F samples aligned to the shifted bits are counted and
// the count is returned tagged with the requester index.
//
// Handshake: req[i] is a level held with data[i] until gnt[i] pulses for one
// cycle; gnt[i] means the word was captured. req is sampled only while idle.
// done is a one-cycle pulse; done_id/match_cnt are valid with it and hold
// until the next done. There is no backpressure on done.
module detector_scheduler
  import detector_scheduler_pkg::*;
#(
  parameter int  N_REQ   = 2,
  parameter int  W       = 8,
  parameter int  DET_LAT = 1,
  localparam int IDW     = $clog2(N_REQ),
  localparam int CW      = $clog2(W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               det_rst,
  output logic               det_x,
  input  logic               det_F,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic [CW-1:0]      match_cnt,
  output state_t             state_dbg
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int LW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, cur_id_q, arb_idx;
  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_any;
  logic [W-1:0]       word_q;
  logic [BW-1:0]      bit_q;
  logic [LW-1:0]      lat_q;
  logic               vld_x_q;
  logic [DET_LAT-1:0] vld_pipe_q;
  logic [CW-1:0]      cnt_q, cnt_inc;
  logic               hit;
  logic [N_REQ-1:0]   gnt_d;
  logic               busy_d, det_rst_d, det_x_d, done_d;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt_next (arb_gnt),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  // A det_F sample counts only when the delayed valid says it belongs to a shifted bit.
  assign hit       = vld_pipe_q[DET_LAT-1] & det_F;
  assign cnt_inc   = cnt_q + CW'(hit);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_any) state_d = S_CLR;
      S_CLR:   state_d = S_SHIFT;
      S_SHIFT: if (bit_q == BW'(W - 1)) state_d = S_DRAIN;
      S_DRAIN: if (lat_q == LW'(DET_LAT - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; values land in the output registers one cycle later.
  always_comb begin
    gnt_d     = (state_q == S_IDLE) ? arb_gnt : '0;
    busy_d    = (state_q != S_IDLE);
    det_rst_d = (state_q == S_CLR);
    det_x_d   = (state_q == S_SHIFT) ? word_q[W-1] : 1'b0;
    done_d    = (state_q == S_DONE);
  end

  // Output registers; reset holds the detector in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= '0;
      busy    <= 1'b0;
      det_rst <= 1'b1;
      det_x   <= 1'b0;
      done    <= 1'b0;
    end else begin
      gnt     <= gnt_d;
      busy    <= busy_d;
      det_rst <= det_rst_d;
      det_x   <= det_x_d;
      done    <= done_d;
    end
  end

  // Datapath: capture, shift, bit/drain counters, valid pipeline, match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      cur_id_q   <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      lat_q      <= '0;
      vld_x_q    <= 1'b0;
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      done_id    <= '0;
      match_cnt  <= '0;
    end else begin
      vld_x_q       <= (state_q == S_SHIFT);
      vld_pipe_q[0] <= vld_x_q;
      for (int i = 1; i < DET_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (state_q == S_CLR) cnt_q <= '0;
      else                  cnt_q <= cnt_inc;
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            word_q   <= data[arb_idx*W +: W];
            cur_id_q <= arb_idx;
            ptr_q    <= (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + IDW'(1);
          end
        end
        S_CLR: begin
          bit_q <= '0;
          lat_q <= '0;
        end
        S_SHIFT: begin
          word_q <= word_q << 1;
          bit_q  <= bit_q + BW'(1);
        end
        S_DRAIN: lat_q <= lat_q + LW'(1);
        S_DONE: begin
          match_cnt <= cnt_inc;
          done_id   <= cur_id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
